pre_if_stage: RTL and testbench

- Pre-IF stage that owns the fetch PC and drives a class-SRAM instruction bus (req / addr_ok / data_ok).
- Delivers {addr_error, inst, pc} bundles to the IF stage through a 1-entry buffer with a valid/allowin handshake.
- Resolves redirects in priority order: exception, then eret, then taken branch, then sequential.
- Cancels wrong-path responses that are still in flight, so IF needs no bus knowledge.

---
 rtl/pre_if_stage_pkg.sv | 17 +
 rtl/pfs_redirect_ctl.sv | 76 +++++++
 rtl/pre_if_stage.sv | 133 +++++++++++++
 tb/tb_pre_if_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pre_if_stage_pkg.sv
// rtl/pre_if_stage_pkg.sv - shared widths, addresses and FSM encodings for the pre-IF stage
package pre_if_stage_pkg;

    localparam int BR_BUS_WD        = 34;
    localparam int PFS_TO_FS_BUS_WD = 65;

    localparam logic [31:0] PFS_RESET_PC = 32'hbfc00000;
    localparam logic [31:0] PFS_EX_ENTRY = 32'hbfc00380;

    typedef enum logic [1:0] {
        PFS_IDLE = 2'd0,
        PFS_REQ  = 2'd1,
        PFS_WAIT = 2'd2,
        PFS_BUF  = 2'd3
    } pfs_state_e;

endpackage

// File: rtl/pfs_redirect_ctl.sv
// rtl/pfs_redirect_ctl.sv - redirect bookkeeping: pending flush target, delay-slot branch target, next_pc
module pfs_redirect_ctl
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY = PFS_EX_ENTRY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BR_BUS_WD-1:0] br_bus,
    input  logic                 ws_ex,
    input  logic                 eret_flush,
    input  logic [31:0]          cp0_epc,
    input  logic [31:0]          pc,
    input  logic                 consume,
    output logic                 flush,
    output logic                 kill,
    output logic [31:0]          next_pc
);

    logic        ds_fetched;
    logic        br_taken;
    logic [31:0] br_target;
    logic        wb_flush;
    logic        ds_now;
    logic [31:0] flush_target;

    logic        redir_pending;
    logic [31:0] redir_target;
    logic        ds_wait;
    logic [31:0] ds_target;

    assign ds_fetched = br_bus[33];
    assign br_taken   = br_bus[32];
    assign br_target  = br_bus[31:0];

    // A branch is ignored when WB flushes in the same cycle.
    assign wb_flush     = ws_ex | eret_flush;
    assign flush        = wb_flush | (br_taken & ds_fetched);
    assign ds_now       = br_taken & ~ds_fetched & ~wb_flush;
    assign flush_target = ws_ex      ? EX_ENTRY :
                          eret_flush ? cp0_epc  : br_target;

    assign kill = flush | redir_pending;

    always_comb begin
        next_pc = pc + 32'd4;
        if (flush)
            next_pc = flush_target;
        else if (redir_pending)
            next_pc = redir_target;
        else if (ds_now)
            next_pc = br_target;
        else if (ds_wait)
            next_pc = ds_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redir_pending <= 1'b0;
            redir_target  <= 32'd0;
            ds_wait       <= 1'b0;
            ds_target     <= 32'd0;
        end else if (consume) begin
            redir_pending <= 1'b0;
            ds_wait       <= 1'b0;
        end else if (flush) begin
            redir_pending <= 1'b1;
            redir_target  <= flush_target;
            ds_wait       <= 1'b0;
        end else if (ds_now) begin
            ds_wait   <= 1'b1;
            ds_target <= br_target;
        end
    end

endmodule

// File: rtl/pre_if_stage.sv
// rtl/pre_if_stage.sv - fetch PC owner, instruction SRAM requester and 1-entry bundle buffer toward IF
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PFS_RESET_PC,
    parameter logic [31:0] EX_ENTRY = PFS_EX_ENTRY
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fs_allowin,
    input  logic [BR_BUS_WD-1:0]        br_bus,
    input  logic                        ws_ex,
    input  logic                        eret_flush,
    input  logic [31:0]                 cp0_epc,
    output logic                        pfs_to_fs_valid,
    output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
    output logic                        inst_sram_req,
    output logic                        inst_sram_wr,
    output logic [1:0]                  inst_sram_size,
    output logic [31:0]                 inst_sram_addr,
    output logic [31:0]                 inst_sram_wdata,
    input  logic                        inst_sram_addr_ok,
    input  logic                        inst_sram_data_ok,
    input  logic [31:0]                 inst_sram_rdata
);

    pfs_state_e                  state, state_nxt;
    logic [31:0]                 pc, pc_nxt;
    logic                        cancel, cancel_nxt;
    logic [PFS_TO_FS_BUS_WD-1:0] fs_buf, fs_buf_nxt;
    logic                        consume;
    logic                        flush;
    logic                        kill;
    logic [31:0]                 next_pc;

    pfs_redirect_ctl #(
        .EX_ENTRY (EX_ENTRY)
    ) u_redirect_ctl (
        .clk        (clk),
        .reset      (reset),
        .br_bus     (br_bus),
        .ws_ex      (ws_ex),
        .eret_flush (eret_flush),
        .cp0_epc    (cp0_epc),
        .pc         (pc),
        .consume    (consume),
        .flush      (flush),
        .kill       (kill),
        .next_pc    (next_pc)
    );

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_addr  = pc;
    assign inst_sram_wdata = 32'd0;
    assign pfs_to_fs_bus   = fs_buf;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        cancel_nxt      = cancel;
        fs_buf_nxt      = fs_buf;
        consume         = 1'b0;
        pfs_to_fs_valid = 1'b0;
        inst_sram_req   = 1'b0;
        case (state)
            PFS_IDLE: begin
                if (flush) begin
                    pc_nxt  = next_pc;
                    consume = 1'b1;
                end else if (pc[1:0] != 2'b00) begin
                    fs_buf_nxt = {1'b1, 32'd0, pc};
                    state_nxt  = PFS_BUF;
                end else begin
                    state_nxt = PFS_REQ;
                end
            end
            PFS_REQ: begin
                // Address stays on the bus until accepted; a redirect seen meanwhile cancels the reply.
                inst_sram_req = 1'b1;
                if (inst_sram_addr_ok) begin
                    cancel_nxt = kill;
                    state_nxt  = PFS_WAIT;
                end
            end
            PFS_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (cancel || kill) begin
                        cancel_nxt = 1'b0;
                        pc_nxt     = next_pc;
                        consume    = 1'b1;
                        state_nxt  = PFS_IDLE;
                    end else begin
                        fs_buf_nxt = {1'b0, inst_sram_rdata, pc};
                        state_nxt  = PFS_BUF;
                    end
                end else if (flush) begin
                    cancel_nxt = 1'b1;
                end
            end
            PFS_BUF: begin
                if (flush) begin
                    pc_nxt    = next_pc;
                    consume   = 1'b1;
                    state_nxt = PFS_IDLE;
                end else begin
                    pfs_to_fs_valid = 1'b1;
                    if (fs_allowin) begin
                        pc_nxt    = next_pc;
                        consume   = 1'b1;
                        state_nxt = PFS_IDLE;
                    end
                end
            end
            default: state_nxt = PFS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= PFS_IDLE;
            pc     <= RESET_PC;
            cancel <= 1'b0;
            fs_buf <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            cancel <= cancel_nxt;
            fs_buf <= fs_buf_nxt;
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// tb/tb_pre_if_stage.sv - directed self-checking bench for pre_if_stage
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin;
    logic [33:0] br_bus;
    logic        ws_ex;
    logic        eret_flush;
    logic [31:0] cp0_epc;
    logic        pfs_to_fs_valid;
    logic [64:0] pfs_to_fs_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int total = 0;
    int fails = 0;

    logic [64:0] bundle_log[$];
    logic [31:0] req_log[$];

    int          resp_delay = 0;
    bit          outstanding = 0;
    int          dcnt = 0;
    logic [31:0] raddr = 32'd0;

    always #5 clk = ~clk;

    pre_if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allowin        (fs_allowin),
        .br_bus            (br_bus),
        .ws_ex             (ws_ex),
        .eret_flush        (eret_flush),
        .cp0_epc           (cp0_epc),
        .pfs_to_fs_valid   (pfs_to_fs_valid),
        .pfs_to_fs_bus     (pfs_to_fs_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [64:0] good_bundle(input logic [31:0] a);
        return {1'b0, mem_word(a), a};
    endfunction

    // Slave: addr_ok always high, data_ok resp_delay cycles after the handshake.
    always @(negedge clk) begin
        if (reset) begin
            outstanding       = 0;
            inst_sram_data_ok = 1'b0;
        end else begin
            inst_sram_data_ok = 1'b0;
            if (outstanding) begin
                if (dcnt == 0) begin
                    inst_sram_data_ok = 1'b1;
                    inst_sram_rdata   = mem_word(raddr);
                    outstanding       = 0;
                end else begin
                    dcnt = dcnt - 1;
                end
            end
            if (inst_sram_req && inst_sram_addr_ok) begin
                outstanding = 1;
                raddr       = inst_sram_addr;
                dcnt        = resp_delay;
                req_log.push_back(inst_sram_addr);
            end
            if (pfs_to_fs_valid && fs_allowin)
                bundle_log.push_back(pfs_to_fs_bus);
        end
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input logic [31:0] target, input string tag);
        bit found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            #1;
            if (req_log.size() > 0 && req_log[req_log.size()-1] == target)
                found = 1;
        end
        check(tag, 65'(found), 65'd1);
    endtask

    task automatic wait_log(input int n, input string tag);
        bit found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bundle_log.size() >= n)
                found = 1;
        end
        check(tag, 65'(found), 65'd1);
    endtask

    task automatic wait_valid(input string tag);
        bit found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (pfs_to_fs_valid)
                found = 1;
        end
        check(tag, 65'(found), 65'd1);
    endtask

    task automatic eret_in_buf(input logic [31:0] epc);
        @(posedge clk); #1;
        eret_flush = 1'b1;
        cp0_epc    = epc;
        @(negedge clk);
        check("eret_drop_valid", 65'(pfs_to_fs_valid), 65'd0);
        @(posedge clk); #1;
        eret_flush = 1'b0;
    endtask

    initial begin
        int n0;
        int rc;
        int hits;
        logic [64:0] held;

        reset             = 1'b1;
        fs_allowin        = 1'b0;
        br_bus            = 34'd0;
        ws_ex             = 1'b0;
        eret_flush        = 1'b0;
        cp0_epc           = 32'd0;
        inst_sram_addr_ok = 1'b1;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 65'(pfs_to_fs_valid), 65'd0);
        check("rst_req", 65'(inst_sram_req), 65'd0);
        check("rst_bus", pfs_to_fs_bus, 65'd0);
        check("rst_addr", 65'(inst_sram_addr), 65'h0_bfc0_0000);
        check("const_size_wr", 65'({inst_sram_size, inst_sram_wr, inst_sram_wdata}), 65'h4_0000_0000);
        @(posedge clk); #1;
        reset      = 1'b0;
        fs_allowin = 1'b1;

        // Sequential fetch
        wait_log(3, "seq_timeout");
        check("seq_b0", bundle_log[0], good_bundle(32'hbfc00000));
        check("seq_b1", bundle_log[1], good_bundle(32'hbfc00004));
        check("seq_b2", bundle_log[2], good_bundle(32'hbfc00008));
        check("seq_req0", 65'(req_log[0]), 65'h0_bfc0_0000);

        // Exception while the 0xbfc00010 response is in flight
        resp_delay = 3;
        wait_req(32'hbfc00010, "req_10_timeout");
        n0 = bundle_log.size();
        @(posedge clk); #1;
        ws_ex = 1'b1;
        @(posedge clk); #1;
        ws_ex = 1'b0;
        resp_delay = 0;
        wait_req(32'hbfc00380, "req_ex_entry_timeout");
        check("ex_req_after_10", 65'(req_log[req_log.size()-2]), 65'h0_bfc0_0010);
        wait_log(n0 + 1, "ex_bundle_timeout");
        check("ex_bundle", bundle_log[n0], good_bundle(32'hbfc00380));
        hits = 0;
        foreach (bundle_log[i]) if (bundle_log[i][31:0] == 32'hbfc00010) hits++;
        check("no_bundle_10", 65'(hits), 65'd0);
        @(posedge clk); #1;
        fs_allowin = 1'b0;

        // eret to a misaligned target: error bundle without a bus access
        wait_valid("eret_pre_valid_timeout");
        rc = req_log.size();
        eret_in_buf(32'h80001002);
        wait_valid("eret_valid_timeout");
        check("eret_bundle", pfs_to_fs_bus, {1'b1, 32'd0, 32'h80001002});
        check("eret_no_req", 65'(req_log.size()), 65'(rc));
        n0 = bundle_log.size();
        @(posedge clk); #1;
        fs_allowin = 1'b1;
        @(posedge clk); #1;
        fs_allowin = 1'b0;
        check("eret_delivered", bundle_log[n0], {1'b1, 32'd0, 32'h80001002});

        // Taken branch, delay slot not yet fetched
        wait_valid("br_pre_valid_timeout");
        eret_in_buf(32'hbfc00020);
        fs_allowin = 1'b1;
        wait_req(32'hbfc00020, "req_20_timeout");
        n0 = bundle_log.size();
        @(posedge clk); #1;
        br_bus = {2'b01, 32'hbfc00100};
        @(posedge clk); #1;
        br_bus = 34'd0;
        wait_req(32'hbfc00100, "ds_req_100_timeout");
        check("ds_prev_req", 65'(req_log[req_log.size()-2]), 65'h0_bfc0_0020);
        check("ds_bundle_20", bundle_log[n0], good_bundle(32'hbfc00020));
        @(posedge clk); #1;
        fs_allowin = 1'b0;

        // Taken branch with delay slot already fetched: BUF at 0xbfc00024 dropped
        wait_valid("br2_pre_valid_timeout");
        eret_in_buf(32'hbfc00024);
        wait_valid("buf_24_timeout");
        check("buf_24", pfs_to_fs_bus, good_bundle(32'hbfc00024));
        n0 = bundle_log.size();
        @(posedge clk); #1;
        br_bus     = {2'b11, 32'hbfc00100};
        fs_allowin = 1'b1;
        @(negedge clk);
        check("br_drop_valid", 65'(pfs_to_fs_valid), 65'd0);
        @(posedge clk); #1;
        br_bus     = 34'd0;
        fs_allowin = 1'b0;
        wait_req(32'hbfc00100, "br_req_100_timeout");
        check("br_no_24", 65'(bundle_log.size()), 65'(n0));

        // Backpressure in BUF
        wait_valid("bp_valid_timeout");
        check("bp_bundle", pfs_to_fs_bus, good_bundle(32'hbfc00100));
        held = pfs_to_fs_bus;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold", {62'd0, pfs_to_fs_valid, inst_sram_req, 1'b0}, 65'b100);
            check("bp_stable", pfs_to_fs_bus, held);
        end
        n0 = bundle_log.size();
        @(posedge clk); #1;
        fs_allowin = 1'b1;
        @(posedge clk); #1;
        fs_allowin = 1'b0;
        repeat (8) @(negedge clk);
        check("bp_one_xfer", 65'(bundle_log.size()), 65'(n0 + 1));
        check("bp_xfer_data", bundle_log[n0], held);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
